// File: rtl/ifetch_sa.sv
// rtl/ifetch_sa.sv - set-associative instruction fetch unit with 2-bit BHT prediction
//
// Fetches one instruction per cycle from a 1- or 2-way LRU instruction cache,
// predicts the next PC (JAL always taken, conditional branches by a 2-bit
// counter table) and refills missed blocks through the memory controller.
// Optional gshare indexing of the counter table: define IFETCH_GSHARE_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   rs/lsb/rob_nxt_full downstream full next cycle; blocks delivery
//   inst_rdy, inst, inst_pc, inst_pred_jump   decoder-side output, registered
//   mc_en, mc_pc        refill request (held until mc_done), block address
//   mc_done, mc_data    refill completion pulse and block data
//   rob_set_pc_en/pc    redirect from the reorder buffer
//   rob_br/_jump/_pc    committed conditional branch outcome for the BHT
module ifetch_sa #(
    parameter int ADDR_W      = 32,
    parameter int BLK_BYTES   = 64,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int BHT_ENTRIES = 256,
    parameter int GHR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rs_nxt_full,
    input  logic                   lsb_nxt_full,
    input  logic                   rob_nxt_full,
    output logic                   inst_rdy,
    output logic [31:0]            inst,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic                   inst_pred_jump,
    output logic                   mc_en,
    output logic [ADDR_W-1:0]      mc_pc,
    input  logic                   mc_done,
    input  logic [BLK_BYTES*8-1:0] mc_data,
    input  logic                   rob_set_pc_en,
    input  logic [ADDR_W-1:0]      rob_set_pc,
    input  logic                   rob_br,
    input  logic                   rob_br_jump,
    input  logic [ADDR_W-1:0]      rob_br_pc
);
    localparam int OFF_W = $clog2(BLK_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int BHT_W = $clog2(BHT_ENTRIES);
    localparam int BLK_W = BLK_BYTES * 8;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;

    logic [SETS-1:0]   valid_q [WAYS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [BLK_W-1:0]  data_q  [WAYS][SETS];
    logic [SETS-1:0]   lru_q;               // way to evict next in each set
    logic [1:0]        bht_q   [BHT_ENTRIES];

    logic [IDX_W-1:0]  idx, f_idx;
    logic [TAG_W-1:0]  tag, f_tag;
    logic [OFF_W-3:0]  wsel;
    logic              hit, hit_way, victim, fill, stall, fetch_go;
    logic [1:0]        hit_cnt;
    logic [BLK_W-1:0]  hit_blk;
    logic [31:0]       word;
    logic [ADDR_W-1:0] j_imm, b_imm, pred_pc;
    logic              pred;
    logic [BHT_W-1:0]  ghr_ix, bht_rd_ix, bht_wr_ix;
    logic [1:0]        ctr;

    assign idx   = pc[OFF_W +: IDX_W];
    assign tag   = pc[ADDR_W-1 -: TAG_W];
    assign wsel  = pc[OFF_W-1:2];
    // Refills are installed by the request address, not the current pc,
    // because a redirect may have moved pc while the refill was in flight.
    assign f_idx = mc_pc[OFF_W +: IDX_W];
    assign f_tag = mc_pc[ADDR_W-1 -: TAG_W];

`ifdef IFETCH_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    assign ghr_ix = BHT_W'(ghr);
`else
    assign ghr_ix = BHT_W'({GHR_W{1'b0}});
`endif

    assign bht_rd_ix = pc[BHT_W+1:2] ^ ghr_ix;
    assign bht_wr_ix = rob_br_pc[BHT_W+1:2] ^ ghr_ix;
    assign ctr       = bht_q[bht_rd_ix];

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        hit_cnt = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
                hit_cnt = hit_cnt + 2'd1;
            end
        end
    end

    // First invalid way wins (scan downward so way 0 is taken last), else LRU.
    always_comb begin
        victim = (WAYS == 2) ? lru_q[f_idx] : 1'b0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!valid_q[w][f_idx]) victim = 1'(w);
        end
    end

    assign hit_blk = data_q[hit_way][idx];
    assign word    = hit_blk[{wsel, 5'b0} +: 32];
    assign j_imm   = {{(ADDR_W-21){word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm   = {{(ADDR_W-13){word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};

    always_comb begin
        pred    = 1'b0;
        pred_pc = pc + ADDR_W'(4);
        if (word[6:0] == 7'b1101111) begin
            pred    = 1'b1;
            pred_pc = pc + j_imm;
        end else if (word[6:0] == 7'b1100011 && ctr[1]) begin
            pred    = 1'b1;
            pred_pc = pc + b_imm;
        end
    end

    assign stall    = rs_nxt_full | lsb_nxt_full | rob_nxt_full;
    assign fetch_go = !rob_set_pc_en && hit && !stall;
    assign fill     = (state == S_WAIT) && mc_done;
    assign mc_en    = (state == S_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!hit)   state_nxt = S_WAIT;
            S_WAIT:  if (mc_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= S_IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= '0;
            inst_rdy       <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_pred_jump <= 1'b0;
            mc_pc          <= '0;
            lru_q          <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
`ifdef IFETCH_GSHARE_EN
            ghr <= '0;
`endif
        end else if (rdy) begin
            if (rob_set_pc_en) begin
                pc       <= rob_set_pc;
                inst_rdy <= 1'b0;
            end else if (fetch_go) begin
                inst_rdy       <= 1'b1;
                inst           <= word;
                inst_pc        <= pc;
                inst_pred_jump <= pred;
                pc             <= pred_pc;
                lru_q[idx]     <= ~hit_way;
            end else begin
                inst_rdy <= 1'b0;
            end

            if (state == S_IDLE && !hit)
                mc_pc <= {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

            // Install after the hit-side LRU write so a same-set install wins.
            if (fill) begin
                valid_q[victim][f_idx] <= 1'b1;
                lru_q[f_idx]           <= ~victim;
            end

            if (rob_br) begin
                if (rob_br_jump) begin
                    if (bht_q[bht_wr_ix] != 2'b11) bht_q[bht_wr_ix] <= bht_q[bht_wr_ix] + 2'd1;
                end else begin
                    if (bht_q[bht_wr_ix] != 2'b00) bht_q[bht_wr_ix] <= bht_q[bht_wr_ix] - 2'd1;
                end
`ifdef IFETCH_GSHARE_EN
                ghr <= {ghr[GHR_W-2:0], rob_br_jump};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_q[victim][f_idx]  <= f_tag;
            data_q[victim][f_idx] <= mc_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) (hit_cnt < 2'd2));

    logic unused_bits;
    assign unused_bits = ^{rob_br_pc, ctr[0]};
endmodule

// File: tb/tb_ifetch_sa.sv
// tb/tb_ifetch_sa.sv - directed self-checking bench for ifetch_sa
module tb_ifetch_sa;
    logic         clk = 1'b0;
    logic         rst, rdy, rs_nxt_full, lsb_nxt_full, rob_nxt_full;
    logic         inst_rdy, inst_pred_jump, mc_en, mc_done;
    logic [31:0]  inst, inst_pc, mc_pc, rob_set_pc, rob_br_pc;
    logic [511:0] mc_data;
    logic         rob_set_pc_en, rob_br, rob_br_jump;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_sa dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs_nxt_full(rs_nxt_full), .lsb_nxt_full(lsb_nxt_full), .rob_nxt_full(rob_nxt_full),
        .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc), .inst_pred_jump(inst_pred_jump),
        .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
        .rob_set_pc_en(rob_set_pc_en), .rob_set_pc(rob_set_pc),
        .rob_br(rob_br), .rob_br_jump(rob_br_jump), .rob_br_pc(rob_br_pc)
    );

    // Memory image: JAL +0x40 at 0x10, BEQ x0,x0,-8 at 0x20, ADDI elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0400006F;
        if (a == 32'h20) return 32'hFE000CE3;
        return {a[13:2], 20'h00093};
    endfunction

    function automatic logic [511:0] mem_block(input logic [31:0] base);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[k*32 +: 32] = mem_word(base + 32'(k*4));
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input logic [31:0] a, input logic pj);
        chk("inst_rdy", 32'(inst_rdy), 32'd1);
        chk("inst_pc", inst_pc, a);
        chk("inst", inst, mem_word(a));
        chk("pred_jump", 32'(inst_pred_jump), 32'(pj));
    endtask

    task automatic serve(input logic [31:0] exp_pc);
        int n = 0;
        while (mc_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mc_en_req", 32'(mc_en), 32'd1);
        chk("mc_pc", mc_pc, exp_pc);
        mc_data = mem_block(exp_pc);
        mc_done = 1'b1;
        @(negedge clk);
        mc_done = 1'b0;
        chk("mc_en_drop", 32'(mc_en), 32'd0);
    endtask

    task automatic go(input logic [31:0] a, input logic stall);
        rob_set_pc_en = 1'b1;
        rob_set_pc    = a;
        rob_nxt_full  = stall;
        @(negedge clk);
        rob_set_pc_en = 1'b0;
        chk("redir_rdy", 32'(inst_rdy), 32'd0);
    endtask

    task automatic br_upd(input logic [31:0] a, input logic j, input int times);
        for (int i = 0; i < times; i++) begin
            rob_br = 1'b1; rob_br_pc = a; rob_br_jump = j;
            @(negedge clk);
            rob_br = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rs_nxt_full = 1'b0; lsb_nxt_full = 1'b0; rob_nxt_full = 1'b0;
        mc_done = 1'b0; mc_data = '0; rob_set_pc_en = 1'b0; rob_set_pc = '0;
        rob_br = 1'b0; rob_br_jump = 1'b0; rob_br_pc = '0;
        repeat (3) @(negedge clk);
        chk("rst_inst_rdy", 32'(inst_rdy), 32'd0);
        chk("rst_mc_en", 32'(mc_en), 32'd0);
        chk("rst_mc_pc", mc_pc, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pj", 32'(inst_pred_jump), 32'd0);
        rst = 1'b0;

        // Cold miss, sequential delivery, JAL redirect prediction.
        @(negedge clk);
        serve(32'h0);
        chk("pre_hit_rdy", 32'(inst_rdy), 32'd0);
        for (int a = 0; a <= 16; a += 4) begin
            @(negedge clk);
            chk_inst(32'(a), a == 16);
        end
        @(negedge clk);
        chk("jal_miss_rdy", 32'(inst_rdy), 32'd0);
        serve(32'h40);
        @(negedge clk);
        chk_inst(32'h50, 1'b0);

        // Downstream-full stalls hold pc and deliver it exactly once.
        rob_nxt_full = 1'b1;
        @(negedge clk);
        chk("stall_rdy0", 32'(inst_rdy), 32'd0);
        @(negedge clk);
        chk("stall_rdy1", 32'(inst_rdy), 32'd0);
        chk("stall_hold_pc", inst_pc, 32'h50);
        rob_nxt_full = 1'b0;
        @(negedge clk);
        chk_inst(32'h54, 1'b0);
        lsb_nxt_full = 1'b1;
        @(negedge clk);
        chk("lsb_stall", 32'(inst_rdy), 32'd0);
        lsb_nxt_full = 1'b0;
        @(negedge clk);
        chk_inst(32'h58, 1'b0);
        rob_nxt_full = 1'b1;

        // LRU eviction in set 0: 0x000, 0x400, 0x800.
        go(32'h400, 1'b1);
        serve(32'h400);
        go(32'h800, 1'b1);
        serve(32'h800);
        go(32'h400, 1'b0);
        @(negedge clk);
        chk_inst(32'h400, 1'b0);
        chk("reuse_no_req", 32'(mc_en), 32'd0);
        rob_nxt_full = 1'b1;
        @(negedge clk);
        chk("reuse_no_req2", 32'(mc_en), 32'd0);
        go(32'h0, 1'b1);
        serve(32'h0);

        // Redirect during refill: old block still installed, new request follows.
        go(32'h100, 1'b1);
        @(negedge clk);
        chk("r_mc_en", 32'(mc_en), 32'd1);
        chk("r_mc_pc", mc_pc, 32'h100);
        rob_set_pc_en = 1'b1; rob_set_pc = 32'h200;
        @(negedge clk);
        rob_set_pc_en = 1'b0;
        chk("r_hold_en", 32'(mc_en), 32'd1);
        chk("r_hold_pc", mc_pc, 32'h100);
        serve(32'h100);
        serve(32'h200);
        rob_nxt_full = 1'b0;
        @(negedge clk);
        chk_inst(32'h200, 1'b0);
        rob_nxt_full = 1'b1;
        go(32'h100, 1'b0);
        @(negedge clk);
        chk_inst(32'h100, 1'b0);
        chk("r_installed", 32'(mc_en), 32'd0);
        rob_nxt_full = 1'b1;

        // BHT: weakly not-taken, trained taken, saturate at 0, retrain.
        go(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h24, 1'b0);
        rob_nxt_full = 1'b1;
        br_upd(32'h20, 1'b1, 2);
        go(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h20, 1'b1);
        @(negedge clk); chk_inst(32'h18, 1'b0);
        rob_nxt_full = 1'b1;
        br_upd(32'h20, 1'b0, 5);
        go(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h24, 1'b0);
        rob_nxt_full = 1'b1;
        br_upd(32'h20, 1'b1, 2);
        go(32'h20, 1'b0);
        @(negedge clk); chk_inst(32'h20, 1'b1);
        @(negedge clk); chk_inst(32'h18, 1'b0);
        rob_nxt_full = 1'b1;

        // rdy low while mc_done pulses: refill is not consumed.
        go(32'h300, 1'b0);
        @(negedge clk);
        chk("rdy_req_en", 32'(mc_en), 32'd1);
        chk("rdy_req_pc", mc_pc, 32'h300);
        rdy = 1'b0;
        mc_data = mem_block(32'h300);
        mc_done = 1'b1;
        @(negedge clk);
        rdy = 1'b1;
        mc_done = 1'b0;
        chk("rdy_hold_en", 32'(mc_en), 32'd1);
        @(negedge clk);
        chk("rdy_no_inst", 32'(inst_rdy), 32'd0);
        chk("rdy_still_en", 32'(mc_en), 32'd1);
        serve(32'h300);
        @(negedge clk);
        chk_inst(32'h300, 1'b0);
        rob_nxt_full = 1'b1;

        // Reset in the middle of a refill.
        go(32'h380, 1'b1);
        @(negedge clk);
        chk("mid_en", 32'(mc_en), 32'd1);
        chk("mid_pc", mc_pc, 32'h380);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", 32'(mc_en), 32'd0);
        chk("mid_rst_pc", mc_pc, 32'd0);
        chk("mid_rst_rdy", 32'(inst_rdy), 32'd0);
        rst = 1'b0;
        rob_nxt_full = 1'b0;
        @(negedge clk);
        chk("post_rst_en", 32'(mc_en), 32'd1);
        chk("post_rst_pc", mc_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
